// File: rtl/rr_arb8_pkg.sv
// Shared types and constants for the 8-way round-robin decoder arbiter.
package rr_arb8_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

    // One-hot vector with bit idx set.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input idx_t idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arb8_decode_ctrl_pick.sv
// rr_pick8: combinational circular priority picker. Scans requesters
// starting just after last_ptr_i and wrapping, so the previous owner
// is considered last.
module rr_pick8
    import rr_arb8_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  idx_t             last_ptr_i,
    output logic             any_o,
    output idx_t             winner_o
);

    // First set request bit in circular order after last_ptr_i.
    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx_t cand;
            cand = last_ptr_i + idx_t'(k + 1);
            if (!any_o && req_i[cand]) begin
                any_o    = 1'b1;
                winner_o = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb8_decode_ctrl.sv
// rr_arb8_decode_ctrl: round-robin arbiter sharing one 3-to-8 decoder
// (select + active-low enable) among 8 requesters. A grant is held until
// the owner raises done; one decoder-disabled cycle separates owners.
// Optional forced release after TIMEOUT_CYCLES busy cycles is enabled by
// defining the macro RR_ARB8_TIMEOUT_EN.
module rr_arb8_decode_ctrl
    import rr_arb8_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] sel,
    output logic             en_n,
    output logic [N_REQ-1:0] grant,
    output logic             timeout_o
);

    state_t           state_q, state_d;
    idx_t             sel_q, sel_d;
    logic             en_n_q, en_n_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    idx_t             last_q, last_d;
    logic             pick_any;
    idx_t             pick_idx;

`ifdef RR_ARB8_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    rr_pick8 u_pick (
        .req_i      (req),
        .last_ptr_i (last_q),
        .any_o      (pick_any),
        .winner_o   (pick_idx)
    );

    // Next-state and registered-output values for the IDLE/BUSY FSM.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_n_d  = en_n_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef RR_ARB8_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                en_n_d  = 1'b1;
                grant_d = '0;
                if (pick_any) begin
                    state_d = BUSY;
                    sel_d   = pick_idx;
                    en_n_d  = 1'b0;
                    grant_d = idx_to_onehot(pick_idx);
`ifdef RR_ARB8_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    en_n_d  = 1'b1;
                    grant_d = '0;
                    last_d  = sel_q;
                end
`ifdef RR_ARB8_TIMEOUT_EN
                // done has priority; timeout fires only on the last allowed busy cycle.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    en_n_d    = 1'b1;
                    grant_d   = '0;
                    last_d    = sel_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                en_n_d  = 1'b1;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            en_n_q  <= 1'b1;
            grant_q <= '0;
            last_q  <= idx_t'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_n_q  <= en_n_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef RR_ARB8_TIMEOUT_EN
    // Busy-cycle counter and one-cycle forced-release pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign sel   = sel_q;
    assign en_n  = en_n_q;
    assign grant = grant_q;

    // Output consistency and parameter sanity checks.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ((TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES < (1 << CNT_W)));
            assert ((grant_q == '0) == en_n_q);
            assert (en_n_q || $onehot(grant_q));
            assert (grant_q[sel_q] == ~en_n_q);
        end
    end

endmodule

// File: tb/tb_rr_arb8_decode_ctrl.sv
// Scoreboard bench for rr_arb8_decode_ctrl: the driver pushes the
// expected registered outputs for every cycle, a monitor pops and compares.
module tb_rr_arb8_decode_ctrl;

    localparam int TC = 4;
`ifdef RR_ARB8_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       done;
    logic [7:0] req;
    logic [2:0] sel;
    logic       en_n;
    logic [7:0] grant;
    logic       timeout_o;

    always #5 clk = ~clk;

    rr_arb8_decode_ctrl #(
        .TIMEOUT_CYCLES (TC),
        .CNT_W          (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .en_n      (en_n),
        .grant     (grant),
        .timeout_o (timeout_o)
    );

    typedef struct {
        logic [2:0] sel;
        logic       en_n;
        logic [7:0] grant;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: owner (-1 when none), last owner, busy cycles used.
    int   m_owner = -1;
    int   m_last  = 7;
    int   m_sel   = 0;
    int   m_used  = 0;
    bit   m_to    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(input logic [7:0] r, input logic d, input logic rn);
        exp_t e;
        if (!rn) begin
            m_owner = -1; m_last = 7; m_sel = 0; m_used = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                int idx;
                idx = (m_last + k) % 8;
                if (m_owner < 0 && r[idx]) begin
                    m_owner = idx;
                    m_sel   = idx;
                    m_used  = 0;
                end
            end
        end else begin
            m_used = m_used + 1;
            if (d) begin
                m_last = m_owner; m_owner = -1; m_to = 1'b0;
            end else if (TO_EN && m_used >= TC) begin
                m_last = m_owner; m_owner = -1; m_to = 1'b1;
            end else begin
                m_to = 1'b0;
            end
        end
        e.sel   = 3'(m_sel);
        e.en_n  = (m_owner < 0);
        e.grant = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        e.to    = m_to;
        q.push_back(e);
    endtask

    // Apply one cycle of inputs; returns 1 time unit after the clock edge.
    task automatic step(input logic [7:0] r, input logic d, input logic rn);
        req   = r;
        done  = d;
        rst_n = rn;
        model_step(r, d, rn);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_sel",     32'(sel),       32'(e.sel));
                check("sb_en_n",    32'(en_n),      32'(e.en_n));
                check("sb_grant",   32'(grant),     32'(e.grant));
                check("sb_timeout", 32'(timeout_o), 32'(e.to));
            end
        end
    end

    initial begin
        int e_idx;
        int busy_cnt;
        bit released;
        bit to_at_rel;
        bit to_seen;
        logic [7:0] r;

        req = '0; done = 1'b0; rst_n = 1'b0;
        #1;
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);

        // Idle after reset with no requests.
        for (int i = 0; i < 10; i++) step(8'h00, 1'b1, 1'b1);
        check("idle_en_n", 32'(en_n), 32'd1);
        check("idle_grant", 32'(grant), 32'h00);

        // Two requesters, done handoff with one idle cycle.
        step(8'h00, 1'b0, 1'b0);
        step(8'h05, 1'b0, 1'b1);
        check("t2_grant0", 32'(grant), 32'h01);
        check("t2_sel0", 32'(sel), 32'd0);
        step(8'h05, 1'b0, 1'b1);
        step(8'h05, 1'b0, 1'b1);
        step(8'h05, 1'b1, 1'b1);
        check("t2_release_en_n", 32'(en_n), 32'd1);
        check("t2_release_sel", 32'(sel), 32'd0);
        step(8'h05, 1'b0, 1'b1);
        check("t2_grant2", 32'(grant), 32'h04);
        check("t2_sel2", 32'(sel), 32'd2);
        step(8'h00, 1'b1, 1'b1);

        // All requesting, done every busy cycle: strict rotation 0..7,0.
        step(8'h00, 1'b0, 1'b0);
        e_idx = 0;
        for (int i = 0; i < 40 && e_idx < 9; i++) begin
            step(8'hFF, (m_owner >= 0), 1'b1);
            if (en_n == 1'b0) begin
                check("t3_rr_order", 32'(sel), 32'(e_idx % 8));
                e_idx++;
            end
        end
        check("t3_rr_count", 32'(e_idx), 32'd9);
        step(8'h00, 1'b1, 1'b1);

        // Pointer wrap: after owner 5, requesters 0 and 5 -> 0 wins.
        step(8'h00, 1'b0, 1'b0);
        step(8'h20, 1'b0, 1'b1);
        check("t4_owner5", 32'(grant), 32'h20);
        step(8'h20, 1'b1, 1'b1);
        step(8'h21, 1'b0, 1'b1);
        check("t4_wrap_sel", 32'(sel), 32'd0);
        check("t4_wrap_grant", 32'(grant), 32'h01);
        step(8'h00, 1'b1, 1'b1);

        // Owner never signals done.
        step(8'h00, 1'b0, 1'b0);
        busy_cnt = 0; released = 1'b0; to_at_rel = 1'b0; to_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(8'h08, 1'b0, 1'b1);
            if (timeout_o) to_seen = 1'b1;
            if (!released) begin
                if (en_n == 1'b0) busy_cnt++;
                else begin
                    released  = 1'b1;
                    to_at_rel = timeout_o;
                end
            end
        end
        if (TO_EN) begin
            check("t5_busy_cycles", 32'(busy_cnt), 32'(TC));
            check("t5_timeout_pulse", 32'(to_at_rel), 32'd1);
        end else begin
            check("t5_held_cycles", 32'(busy_cnt), 32'd60);
            check("t5_no_timeout", 32'(to_seen), 32'd0);
        end
        step(8'h00, 1'b1, 1'b1);

        // Reset mid-busy clears the grant and the rotation pointer.
        step(8'h00, 1'b0, 1'b0);
        step(8'h08, 1'b0, 1'b1);
        step(8'h08, 1'b0, 1'b1);
        check("t6_busy_grant", 32'(grant), 32'h08);
        step(8'h88, 1'b0, 1'b0);
        check("t6_rst_en_n", 32'(en_n), 32'd1);
        check("t6_rst_grant", 32'(grant), 32'h00);
        step(8'h88, 1'b0, 1'b1);
        check("t6_after_rst_sel", 32'(sel), 32'd3);
        check("t6_after_rst_grant", 32'(grant), 32'h08);
        step(8'h00, 1'b1, 1'b1);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) != 0));
        end

        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        #5;
        check("sb_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
